// File: rtl/rvfi_trace_fifo.sv
// Retire-trace FIFO: compacts up to NrCommitPorts RVFI records per cycle, stamps them
// with a running order number and exposes them one at a time through a valid/ready port.
module rvfi_trace_fifo #(
    parameter int NrCommitPorts = 2,
    parameter int RecW          = 256,
    parameter int Depth         = 8,
    parameter int OrderW        = 64,
    parameter int DropW         = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [NrCommitPorts-1:0]      rec_valid_i,
    input  logic [NrCommitPorts*RecW-1:0] rec_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [RecW-1:0]               out_rec_o,
    output logic [OrderW-1:0]             out_order_o,
    output logic [DropW-1:0]              drop_cnt_o,
    output logic                          overflow_o,
    output logic [$clog2(Depth):0]        level_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;

    logic [RecW-1:0]          mem_rec   [Depth];
    logic [OrderW-1:0]        mem_order [Depth];
    logic [PtrW-1:0]          wr_ptr;
    logic [PtrW-1:0]          rd_ptr;
    logic [CntW-1:0]          count;
    logic [OrderW-1:0]        order_q;

    logic [NrCommitPorts-1:0] acc;
    logic [CntW-1:0]          acc_n;
    logic [CntW-1:0]          slot [NrCommitPorts];
    logic [CntW-1:0]          free;
    logic                     push;
    logic                     drop;
    logic                     pop;
    logic [DropW:0]           drop_sum;

    // Modulo-Depth pointer advance; also correct for the degenerate Depth=1 case.
    function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                                 input logic [CntW-1:0] off);
        int unsigned sum;
        sum = 32'(base) + 32'(off);
        return PtrW'(sum % Depth);
    endfunction

    // Each accepted port's slot is the number of accepted ports below it, so gaps compact away.
    always_comb begin
        acc   = enable_i ? rec_valid_i : '0;
        acc_n = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            slot[i] = acc_n;
            acc_n   = acc_n + CntW'(acc[i]);
        end
    end

    // Free space ignores a same-cycle pop, so a full FIFO drops arrivals even while draining.
    assign free     = CntW'(Depth) - count;
    assign push     = (acc_n != '0) && (acc_n <= free);
    assign drop     = (acc_n != '0) && (acc_n > free);
    assign pop      = out_valid_o && out_ready_i;
    assign drop_sum = {1'b0, drop_cnt_o} + (DropW+1)'(acc_n);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int d = 0; d < Depth; d++) begin
                mem_rec[d]   <= '0;
                mem_order[d] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < NrCommitPorts; i++) begin
                if (acc[i]) begin
                    mem_rec[wrap_add(wr_ptr, slot[i])]   <= rec_i[i*RecW +: RecW];
                    mem_order[wrap_add(wr_ptr, slot[i])] <= order_q + OrderW'(slot[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            order_q    <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_add(wr_ptr, acc_n);
            end
            if (pop) begin
                rd_ptr <= wrap_add(rd_ptr, CntW'(1));
            end
            count   <= count + (push ? acc_n : '0) - CntW'(pop);
            order_q <= order_q + OrderW'(acc_n);
            if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[DropW] ? '1 : drop_sum[DropW-1:0];
            end
        end
    end

    assign out_valid_o = (count != '0);
    assign out_rec_o   = mem_rec[rd_ptr];
    assign out_order_o = mem_order[rd_ptr];
    assign level_o     = count;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Directed bench for rvfi_trace_fifo: hand-computed records are queued as stimulus is issued
// and a negedge monitor pops and compares each record the DUT hands out.
module tb_rvfi_trace_fifo;

    typedef struct packed {
        logic [31:0] rec;
        logic [63:0] order;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  rec_valid;
    logic [63:0] rec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rec;
    logic [63:0] out_order;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic [3:0]  level;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    rvfi_trace_fifo #(
        .NrCommitPorts(2),
        .RecW(32),
        .Depth(8),
        .OrderW(64),
        .DropW(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .rec_valid_i(rec_valid),
        .rec_i(rec),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_rec_o(out_rec),
        .out_order_o(out_order),
        .drop_cnt_o(drop_cnt),
        .overflow_o(overflow),
        .level_o(level)
    );

    always #5 clk = ~clk;

    // A handshake seen at the negedge completes on the next posedge, so the head is compared here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop got rec=%h order=%0d required no output", out_rec, out_order);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_rec !== mon_e.rec || out_order !== mon_e.order) begin
                    errors++;
                    $display("[TB] FAIL pop_data got rec=%h order=%0d required rec=%h order=%0d",
                             out_rec, out_order, mon_e.rec, mon_e.order);
                end
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic [1:0] v, input logic [31:0] r0,
                                 input logic [31:0] r1, input logic rdy);
        enable    = en;
        rec_valid = v;
        rec       = {r1, r0};
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [31:0] r, input logic [63:0] o);
        exp_t e;
        e.rec   = r;
        e.order = o;
        exp_q.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        rec_valid = 2'b00;
        rec       = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_level", 64'(level), 64'd0);
        checkOutput("reset_drop", 64'(drop_cnt), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_rec", 64'(out_rec), 64'd0);
        checkOutput("reset_order", out_order, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single port, one-cycle latency, then empty again.
        pushExp(32'hAAAA_0000, 64'd0);
        applyStimulus(1'b1, 2'b01, 32'hAAAA_0000, 32'h0, 1'b1);
        checkOutput("single_valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("single_drained", 64'(out_valid), 64'd0);

        // Compaction across a gap in rec_valid, with the sink stalled.
        pushExp(32'hB000_0000, 64'd1);
        pushExp(32'hB000_0001, 64'd2);
        applyStimulus(1'b1, 2'b11, 32'hB000_0000, 32'hB000_0001, 1'b0);
        pushExp(32'hC000_0001, 64'd3);
        applyStimulus(1'b1, 2'b10, 32'hDEAD_BEEF, 32'hC000_0001, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
        checkOutput("compact_level", 64'(level), 64'd3);
        checkOutput("hold_rec", 64'(out_rec), 64'hB000_0000);
        checkOutput("hold_order", out_order, 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("compact_drained", 64'(level), 64'd0);

        // Fill to Depth, then overflow drops whole cycles while stamps keep advancing.
        for (int c = 0; c < 4; c++) begin
            pushExp(32'h1000_0000 + 32'(2*c), 64'(4 + 2*c));
            pushExp(32'h1000_0001 + 32'(2*c), 64'(5 + 2*c));
            applyStimulus(1'b1, 2'b11, 32'h1000_0000 + 32'(2*c), 32'h1000_0001 + 32'(2*c), 1'b0);
        end
        checkOutput("full_level", 64'(level), 64'd8);
        checkOutput("no_overflow_yet", 64'(overflow), 64'd0);
        applyStimulus(1'b1, 2'b11, 32'hBAD0_0000, 32'hBAD0_0001, 1'b0);
        checkOutput("drop1_cnt", 64'(drop_cnt), 64'd2);
        checkOutput("drop1_overflow", 64'(overflow), 64'd1);
        checkOutput("drop1_level", 64'(level), 64'd8);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("drain1_level", 64'(level), 64'd7);
        applyStimulus(1'b1, 2'b11, 32'hBAD0_0002, 32'hBAD0_0003, 1'b0);
        checkOutput("drop2_cnt", 64'(drop_cnt), 64'd4);
        checkOutput("drop2_level", 64'(level), 64'd7);
        pushExp(32'h2000_0000, 64'd16);
        applyStimulus(1'b1, 2'b01, 32'h2000_0000, 32'h0, 1'b0);
        checkOutput("refill_level", 64'(level), 64'd8);

        // Full with simultaneous pop: arrival dropped, head still leaves.
        applyStimulus(1'b1, 2'b01, 32'hBAD0_0004, 32'h0, 1'b1);
        checkOutput("fullpop_level", 64'(level), 64'd7);
        checkOutput("fullpop_drop", 64'(drop_cnt), 64'd5);

        // Disabled cycle: nothing written, order stamp and drop count unchanged.
        applyStimulus(1'b0, 2'b11, 32'hBAD0_0005, 32'hBAD0_0006, 1'b0);
        checkOutput("disable_level", 64'(level), 64'd7);
        checkOutput("disable_drop", 64'(drop_cnt), 64'd5);
        pushExp(32'h3000_0000, 64'd18);
        applyStimulus(1'b1, 2'b01, 32'h3000_0000, 32'h0, 1'b0);
        checkOutput("post_disable_level", 64'(level), 64'd8);

        // Drain to 5, then asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("middrain_level", 64'(level), 64'd5);
        rst = 1'b1;
        exp_q.delete();
        #2;
        checkOutput("areset_valid", 64'(out_valid), 64'd0);
        checkOutput("areset_level", 64'(level), 64'd0);
        checkOutput("areset_drop", 64'(drop_cnt), 64'd0);
        checkOutput("areset_overflow", 64'(overflow), 64'd0);
        checkOutput("areset_rec", 64'(out_rec), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushExp(32'h5A5A_5A5A, 64'd0);
        applyStimulus(1'b1, 2'b01, 32'h5A5A_5A5A, 32'h0, 1'b1);
        checkOutput("post_reset_order", out_order, 64'd0);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("final_valid", 64'(out_valid), 64'd0);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout got running required finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/rvfi_trace_fifo.md
# rvfi_trace_fifo

Retire-trace buffer sitting directly downstream of the RVFI packing stage. Each cycle it accepts up to NrCommitPorts retirement records, stamps each with a monotonically increasing order number, and compacts them in port order into a single-output FIFO. A trace sink (tracer, DPI bridge or debug streamer) drains it through a valid/ready handshake. Overflow is handled atomically per cycle and counted.

## Interface
- NrCommitPorts, 2: retire ports per cycle (1..4)
- RecW, 256: width of one flattened RVFI record
- Depth, 8: FIFO entries; power of two, ≥ NrCommitPorts
- OrderW, 64: width of order stamp
- DropW, 16: width of drop counter
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  when 0, incoming records are ignored (not stamped, not counted)
- rec_valid_i  in  NrCommitPorts  per-port record valid (rvfi valid)
- rec_i  in  NrCommitPorts×RecW  per-port record payload
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  sink accepts head entry
- out_rec_o  out  RecW  head record payload
- out_order_o  out  OrderW  head record order stamp
- drop_cnt_o  out  DropW  records dropped, saturating
- overflow_o  out  1  sticky: at least one drop since reset
- level_o  out  $clog2(Depth)+1  current occupancy

## Operation
- Accepted set per cycle: ports i with rec_valid_i[i]=1 and enable_i=1; n = popcount (0..NrCommitPorts).
- Compaction: accepted records written to consecutive entries starting at write pointer, lowest port index first; gaps in rec_valid_i (e.g. 2'b10) do not leave holes.
- Order stamp: k-th accepted record (k=0..n-1) gets order_q+k; order_q += n every enabled cycle regardless of drop, so dropped records leave visible gaps in the stamp sequence. order_q wraps modulo 2^OrderW.
- Space check: free = Depth − count, where count excludes a same-cycle pop (conservative). If n > free, the whole cycle's set is dropped (no partial write); drop_cnt += n saturating at 2^DropW−1; overflow_o set.
- Pop: when out_valid_o && out_ready_i, head advances by one.
- Pointers: wr_ptr/rd_ptr are $clog2(Depth) bits, wrap naturally; count tracked separately (0..Depth). count_next = count + (written ? n : 0) − pop.
- out_valid_o = (count != 0); out_rec_o/out_order_o driven from head entry storage (registered data, no combinational path from rec_i).
- out_ready_i while out_valid_o=0 has no effect.

## Timing
- Reset (rst_i=1, asynchronous): count, pointers, order_q, drop_cnt_o, overflow_o, level_o all 0; out_valid_o=0; out_rec_o/out_order_o=0 (storage cleared). Reset mid-stream discards all entries immediately.
- Write latency: record presented at edge N appears at out_* after edge N (one cycle), if FIFO was empty.
- Throughput: 1 record out per cycle; up to NrCommitPorts in per cycle.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_rec_o/out_order_o hold.
- Full with simultaneous pop and n≥1 arrivals: arrivals dropped (free computed before pop).
- level_o updates one cycle after the edge causing push/pop; equals count register.

## Test plan
- Single port: NrCommitPorts=2, rec_valid_i=2'b01, rec=A, out_ready_i=1 -> next cycle out_valid_o=1, out_rec_o=A, out_order_o=0; following cycle out_valid_o=0.
- Compaction/order: cycle 0 rec_valid_i=2'b11 {A,B}, cycle 1 2'b10 {C}, out_ready_i=0 -> level_o=3; draining yields A/0, B/1, C/2 in order.
- Overflow: Depth=8, out_ready_i=0, four cycles of 2'b11 fill 8; fifth cycle 2'b11 -> dropped, drop_cnt_o=2, overflow_o=1, level_o=8; then after draining one entry, a 2'b11 cycle still drops (free=1<2), drop_cnt_o=4; next entries' stamps show gap (10,11 absent if dropped, 12 next accepted... exact: first drop 8,9; second 10,11).
- Full with pop: level 8, out_ready_i=1, rec_valid_i=2'b01 -> record dropped, level_o=7, drop_cnt_o incremented by 1.
- enable_i=0 with rec_valid_i=2'b11 -> nothing written, order and drop_cnt unchanged.
- Async reset asserted mid-drain with level 5 -> out_valid_o=0, level_o=0, drop_cnt_o=0, overflow_o=0 immediately; first post-reset record stamped 0.
